// File: rtl/dly_cal_pkg.sv
// Shared definitions for the PLL fine-delay calibrator: tap geometry, run-length
// width, FSM state encoding and the window-centre helper.
package dly_cal_pkg;

    localparam int NUM_TAPS = 16;
    localparam int TAP_W    = 4;
    localparam int LEN_W    = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        NEXT    = 3'd3,
        DECIDE  = 3'd4,
        LOCKED  = 3'd5,
        FAILED  = 3'd6
    } state_t;

    // Centre of a run starting at lo with length len, rounding towards the low tap.
    function automatic logic [TAP_W-1:0] centre_tap(input logic [TAP_W-1:0] lo,
                                                    input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] half;
        half = (len - 1'b1) >> 1;
        return lo + half[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/dly_cal_window_tracker.sv
// Longest-run tracker over the swept taps. One pass bit arrives per tap in
// ascending tap order; the tracker keeps the run currently open and the best
// closed run. A run only replaces the best one when strictly longer, so on a
// tie the lowest-starting run is kept. The outputs already fold in a run that
// is still open, so the owner sees the final answer in the close cycle.
module dly_cal_window_tracker
    import dly_cal_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_pass_vld,
    input  logic             i_pass,
    input  logic [TAP_W-1:0] i_tap,
    input  logic             i_close,
    output logic [TAP_W-1:0] o_best_lo,
    output logic [LEN_W-1:0] o_best_len
);

    logic [TAP_W-1:0] r_cur_lo;
    logic [LEN_W-1:0] r_cur_len;
    logic [TAP_W-1:0] r_best_lo;
    logic [LEN_W-1:0] r_best_len;
    logic             w_cur_better;

    assign w_cur_better = (r_cur_len > r_best_len);
    assign o_best_lo    = w_cur_better ? r_cur_lo  : r_best_lo;
    assign o_best_len   = w_cur_better ? r_cur_len : r_best_len;

    // Extend the open run on a pass; on a fail or at close, promote it if strictly longer.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cur_lo   <= '0;
            r_cur_len  <= '0;
            r_best_lo  <= '0;
            r_best_len <= '0;
        end else if (i_pass_vld && i_pass) begin
            if (r_cur_len == '0) begin
                r_cur_lo <= i_tap;
            end
            r_cur_len <= r_cur_len + 1'b1;
        end else if (i_pass_vld || i_close) begin
            if (w_cur_better) begin
                r_best_lo  <= r_cur_lo;
                r_best_len <= r_cur_len;
            end
            r_cur_len <= '0;
        end
    end

endmodule

// File: rtl/dly_adj_calibrator.sv
// PLL fine-delay (DlyAdj) calibrator. On start, sweeps all 16 taps: each tap
// is held for SETTLE_CYCLES, then scored over SAMPLE_CYCLES from the pattern
// checker (pass = at least one compared word and no mismatch). The longest run
// of passing taps (lowest wins a tie) is parked on its centre when it is at
// least MIN_WINDOW long; otherwise the delay returns to DEFAULT_TAP.
// Optional feature macro: DLY_CAL_PASSMAP_EN adds pass_map[15:0], the per-tap
// pass bits of the last sweep.
// Handshake: start is a single-cycle request taken only in IDLE/LOCKED/FAILED;
// while busy it is ignored. done pulses for one cycle when the sweep ends.
module dly_adj_calibrator
    import dly_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64,
    parameter int MIN_WINDOW    = 3,
    parameter int DEFAULT_TAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             chk_valid,
    input  logic             chk_err,
    output logic [TAP_W-1:0] dly_adj,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             fail,
    output logic [TAP_W-1:0] win_lo,
    output logic [TAP_W-1:0] win_hi,
`ifdef DLY_CAL_PASSMAP_EN
    output logic [NUM_TAPS-1:0] pass_map,
`endif
    output state_t           dbg_state
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
    localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_WINDOW);

    state_t           r_state;
    state_t           w_next;
    logic             w_sweep_start;
    logic [CNT_W-1:0] r_cnt;
    logic [TAP_W-1:0] r_tap;
    logic             r_seen;
    logic             r_err;
    logic             r_locked;
    logic             r_fail;
    logic [TAP_W-1:0] r_win_lo;
    logic [TAP_W-1:0] r_win_hi;
    logic             w_tap_pass;
    logic             w_win_ok;
    logic [TAP_W-1:0] w_best_lo;
    logic [LEN_W-1:0] w_best_len;

    assign w_tap_pass = r_seen & ~r_err;
    assign w_win_ok   = (w_best_len >= MIN_LEN);

    assign dly_adj   = r_tap;
    assign locked    = r_locked;
    assign fail      = r_fail;
    assign win_lo    = r_win_lo;
    assign win_hi    = r_win_hi;
    assign dbg_state = r_state;

    dly_cal_window_tracker u_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_sweep_start),
        .i_pass_vld (r_state == NEXT),
        .i_pass     (w_tap_pass),
        .i_tap      (r_tap),
        .i_close    (r_state == DECIDE),
        .o_best_lo  (w_best_lo),
        .o_best_len (w_best_len)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the busy/done status derived from the current state.
    always_comb begin
        w_next        = r_state;
        w_sweep_start = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            IDLE, LOCKED, FAILED: begin
                if (start) begin
                    w_next        = SETTLE;
                    w_sweep_start = 1'b1;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (r_cnt == SETTLE_LAST) w_next = MEASURE;
            end
            MEASURE: begin
                busy = 1'b1;
                if (r_cnt == SAMPLE_LAST) w_next = NEXT;
            end
            NEXT: begin
                busy   = 1'b1;
                w_next = (r_tap == LAST_TAP) ? DECIDE : SETTLE;
            end
            DECIDE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = w_win_ok ? LOCKED : FAILED;
            end
            default: w_next = IDLE;
        endcase
    end

    // Phase counter: runs only while staying in SETTLE or MEASURE, restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == SETTLE || r_state == MEASURE) && (w_next == r_state)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Per-tap score flags: cleared while settling, saturating while measuring.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_state == SETTLE) begin
            r_seen <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_state == MEASURE) begin
            if (chk_valid)            r_seen <= 1'b1;
            if (chk_valid && chk_err) r_err  <= 1'b1;
        end
    end

    // Tap select and calibration result: step taps during the sweep, park on the outcome at DECIDE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap    <= DEF_TAP;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
            r_win_lo <= '0;
            r_win_hi <= '0;
        end else if (w_sweep_start) begin
            r_tap    <= '0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
            r_win_lo <= '0;
            r_win_hi <= '0;
        end else if (r_state == NEXT && r_tap != LAST_TAP) begin
            r_tap <= r_tap + 1'b1;
        end else if (r_state == DECIDE) begin
            if (w_win_ok) begin
                r_tap    <= centre_tap(w_best_lo, w_best_len);
                r_locked <= 1'b1;
                r_win_lo <= w_best_lo;
                r_win_hi <= w_best_lo + TAP_W'(w_best_len - 1'b1);
            end else begin
                r_tap  <= DEF_TAP;
                r_fail <= 1'b1;
            end
        end
    end

`ifdef DLY_CAL_PASSMAP_EN
    logic [NUM_TAPS-1:0] r_pass_map;

    assign pass_map = r_pass_map;

    // Record each tap's pass bit in its NEXT cycle; a new sweep starts from an empty map.
    always_ff @(posedge clk) begin
        if (rst || w_sweep_start) begin
            r_pass_map <= '0;
        end else if (r_state == NEXT) begin
            r_pass_map[r_tap] <= w_tap_pass;
        end
    end
`endif

endmodule
